// File: rtl/rgb_decoder_pkg.sv
// Shared definitions for the colour-code <-> 24-bit RGB conversion.
//   state_e      : decoder FSM states
//   COLOUR_W     : width of a colour code {R,G,B}
//   RGB_W        : width of an RGB word {R[23:16],G[15:8],B[7:0]}
//   code_to_rgb  : the colour table, also used by the encoder side
package rgb_decoder_pkg;

  localparam int unsigned COLOUR_W  = 3;
  localparam int unsigned RGB_W     = 24;
  localparam int unsigned CHAN_W    = 8;
  localparam int unsigned NUM_CODES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Each code bit drives its whole channel fully on or fully off.
  function automatic logic [RGB_W-1:0] code_to_rgb(input logic [COLOUR_W-1:0] c);
    return {{CHAN_W{c[2]}}, {CHAN_W{c[1]}}, {CHAN_W{c[0]}}};
  endfunction

endpackage

// File: rtl/rgb_decoder.sv
// RGB word -> colour code decoder with a sequential table search.
//   clk        : system clock, rising edge
//   rst        : synchronous active-low reset
//   rgb_in     : {R,G,B} word, taken when valid_in is high in IDLE
//   valid_in   : rgb_in valid
//   ready_out  : high only while IDLE
//   colour_out : decoded code {R,G,B}
//   match      : 1 = exact table hit, 0 = threshold fallback
//   valid_out  : result valid, held until ready_in
//   ready_in   : downstream accepts the result
//   miss_count : saturating count of non-exact decodes
module rgb_decoder
  import rgb_decoder_pkg::*;
#(
  parameter logic [7:0]  THRESH = 8'h80,
  parameter int unsigned MISS_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RGB_W-1:0]    rgb_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                match,
  output logic                valid_out,
  input  logic                ready_in,
  output logic [MISS_W-1:0]   miss_count
);

  localparam logic [COLOUR_W-1:0] LAST_IDX = COLOUR_W'(NUM_CODES - 1);

  state_e                state_q, state_d;
  logic [RGB_W-1:0]      word_q, word_d;
  logic [COLOUR_W-1:0]   idx_q, idx_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  match_q, match_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic [COLOUR_W-1:0]   fallback;

  // Per-channel threshold code used when no table entry matches.
  assign fallback = {word_q[23:16] >= THRESH, word_q[15:8] >= THRESH, word_q[7:0] >= THRESH};

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    colour_d = colour_q;
    match_d  = match_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    miss_d   = miss_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          word_d  = rgb_in;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (word_q == code_to_rgb(idx_q)) begin
          colour_d = idx_q;
          match_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (idx_q == LAST_IDX) begin
          colour_d = fallback;
          match_d  = 1'b0;
          valid_d  = 1'b1;
          if (miss_q != '1) begin
            miss_d = miss_q + MISS_W'(1);
          end
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q + COLOUR_W'(1);
        end
      end
      ST_DONE: begin
        // Returning to IDLE here; the accept happens on a later edge.
        if (ready_in) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      idx_q    <= '0;
      colour_q <= '0;
      match_q  <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      colour_q <= colour_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      miss_q   <= miss_d;
    end
  end

  assign ready_out  = ready_q;
  assign colour_out = colour_q;
  assign match      = match_q;
  assign valid_out  = valid_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_rgb_decoder.sv
// Self-checking bench for rgb_decoder: a transaction-level model predicts the
// handshake timing and results; dut (MISS_W=8) and dut2 (MISS_W=2) share inputs.
module tb_rgb_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgb_in;
  logic        valid_in;
  logic        ready_in;

  logic        ready_out, match, valid_out;
  logic [2:0]  colour_out;
  logic [7:0]  miss_count;
  logic        d2_ready_out, d2_match, d2_valid_out;
  logic [2:0]  d2_colour_out;
  logic [1:0]  d2_miss_count;

  always #5 clk = ~clk;

  rgb_decoder #(.THRESH(8'h80), .MISS_W(8)) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .valid_in(valid_in),
    .ready_out(ready_out), .colour_out(colour_out), .match(match),
    .valid_out(valid_out), .ready_in(ready_in), .miss_count(miss_count)
  );

  rgb_decoder #(.THRESH(8'h80), .MISS_W(2)) dut2 (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .valid_in(valid_in),
    .ready_out(d2_ready_out), .colour_out(d2_colour_out), .match(d2_match),
    .valid_out(d2_valid_out), .ready_in(ready_in), .miss_count(d2_miss_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected decode: a word made only of 00/FF channels is a table entry whose
  // code is the set of FF channels; anything else falls back to thresholds.
  task automatic exp_of(input logic [23:0] w, output logic [2:0] c, output bit hit,
                        output int lat);
    int r, g, b;
    r = int'(w[23:16]);
    g = int'(w[15:8]);
    b = int'(w[7:0]);
    hit = (r == 0 || r == 255) && (g == 0 || g == 255) && (b == 0 || b == 255);
    if (hit) begin
      c   = {r == 255, g == 255, b == 255};
      lat = int'(c) + 1;
    end else begin
      c   = {r >= 128, g >= 128, b >= 128};
      lat = 8;
    end
  endtask

  // Transaction-level model.
  bit         m_ready, m_valid, m_match, p_hit;
  logic [2:0] m_colour, p_colour;
  int         m_wait, m_miss, m_miss2;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_ready = 1; m_valid = 0; m_colour = 0; m_match = 0;
      m_miss = 0; m_miss2 = 0; m_wait = 0;
    end else if (m_ready) begin
      if (valid_in) begin
        exp_of(rgb_in, p_colour, p_hit, m_wait);
        m_ready = 0;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid  = 1;
        m_colour = p_colour;
        m_match  = p_hit;
        if (!p_hit) begin
          if (m_miss < 255) m_miss++;
          if (m_miss2 < 3) m_miss2++;
        end
      end
    end else if (m_valid && ready_in) begin
      m_valid = 0;
      m_ready = 1;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_out", ready_out, m_ready);
      chk("valid_out", valid_out, m_valid);
      chk("colour_out", colour_out, m_colour);
      chk("match", match, m_match);
      chk("miss_count", miss_count, m_miss);
      chk("d2_ready_out", d2_ready_out, m_ready);
      chk("d2_valid_out", d2_valid_out, m_valid);
      chk("d2_colour_out", d2_colour_out, m_colour);
      chk("d2_match", d2_match, m_match);
      chk("d2_miss_count", d2_miss_count, m_miss2);
    end
  end

  // One transaction; returns result and cycles from accept edge to valid_out.
  task automatic txn(input logic [23:0] w, input int hold,
                     output logic [2:0] col, output bit mt, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_out) chk("ready_timeout", 0, 1);
    rgb_in   = w;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'($urandom_range(0, 1));
    rgb_in   = 24'($urandom);
    lat = 0;
    while (!valid_out && lat < 20) begin
      @(negedge clk);
      lat++;
      valid_in = 1'($urandom_range(0, 1));
      rgb_in   = 24'($urandom);
    end
    if (!valid_out) chk("valid_timeout", 0, 1);
    col = colour_out;
    mt  = match;
    for (int i = 0; i < hold; i++) begin
      chk("hold_colour", colour_out, col);
      chk("hold_valid", valid_out, 1);
      chk("hold_ready_out", ready_out, 0);
      @(negedge clk);
      valid_in = 1'($urandom_range(0, 1));
    end
    ready_in = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    ready_in = 1'b0;
    chk("return_idle_ready", ready_out, 1);
    chk("return_idle_valid", valid_out, 0);
  endtask

  logic [2:0]  col;
  bit          mt;
  int          lat;
  logic [23:0] w;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; valid_in = 1'b0; ready_in = 1'b0; rgb_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_ready", ready_out, 1);
    chk("reset_valid", valid_out, 0);
    chk("reset_colour", colour_out, 0);
    chk("reset_miss", miss_count, 0);
    rst = 1'b1;

    txn(24'h000000, 0, col, mt, lat);
    chk("black_code", col, 3'd0); chk("black_match", mt, 1); chk("black_lat", lat, 1);
    txn(24'hFFFFFF, 0, col, mt, lat);
    chk("white_code", col, 3'd7); chk("white_match", mt, 1); chk("white_lat", lat, 8);

    for (int c = 0; c < 8; c++) begin
      txn(rgb_decoder_pkg::code_to_rgb(3'(c)), 0, col, mt, lat);
      chk("table_code", col, c);
      chk("table_match", mt, 1);
      chk("table_lat", lat, c + 1);
    end

    txn(24'hC01020, 0, col, mt, lat);
    chk("c01020_code", col, 3'b100); chk("c01020_match", mt, 0);
    chk("c01020_lat", lat, 8); chk("c01020_miss", miss_count, 1);
    txn(24'h808080, 0, col, mt, lat);
    chk("808080_code", col, 3'b111); chk("808080_match", mt, 0);

    txn(24'h00FF00, 5, col, mt, lat);
    chk("stall_code", col, 3'd2);

    // Reset while the search index is 3.
    @(negedge clk);
    rgb_in = 24'h123456; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midreset_ready", ready_out, 1);
    chk("midreset_valid", valid_out, 0);
    chk("midreset_miss", miss_count, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midreset_no_result", valid_out, 0);
    end

    for (int i = 0; i < 5; i++) begin
      txn(24'h123456 + 24'(i), 0, col, mt, lat);
    end
    chk("five_miss_w8", miss_count, 5);
    chk("five_miss_w2", d2_miss_count, 3);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: w = rgb_decoder_pkg::code_to_rgb(3'($urandom_range(0, 7)));
        1: w = 24'($urandom);
        default: w = rgb_decoder_pkg::code_to_rgb(3'($urandom_range(0, 7)))
                     ^ (24'd1 << $urandom_range(0, 23));
      endcase
      txn(w, $urandom_range(0, 3), col, mt, lat);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
